hazard_ctrl: RTL

- Pipeline control unit for the 5-stage RV32I core. It sits beside the ID stage, where the immediate extender and register file are read.
- Decides per cycle whether to advance, stall, flush or freeze the IF/ID/EX/MEM/WB registers.
- Generates EX-stage operand forwarding selects.
- Tracks memory wait-states, with a timeout error and performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/hazard_ctrl_fwd_unit.sv | 24 ++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [4:0] X0 = 5'd0;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand.
// The MEM result is younger than the WB result, so it wins.
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] fwd_sel
);

   // Pick the youngest in-flight producer of ex_rs; x0 is never forwarded.
   always_comb begin
      fwd_sel = FWD_RF;
      if (mem_reg_write && (mem_rd != X0) && (mem_rd == ex_rs)) begin
         fwd_sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != X0) && (wb_rd == ex_rs)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule : fwd_unit

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage RV32I core: freeze on memory wait,
// flush on taken branch, single bubble on load-use, operand forwarding,
// memory-timeout detection and stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             im_ready,
   input  logic             dm_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             pipe_stall,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   hz_state_e        state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic       ready;
   logic       freeze;
   logic       load_use;
   logic [1:0] fwd_a_raw, fwd_b_raw;

   assign ready    = im_ready & dm_ready;
   assign freeze   = ~ready | (state_q == ERROR);
   assign load_use = ex_mem_read && (ex_rd != X0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   fwd_unit u_fwd_a (
      .ex_rs         (ex_rs1),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd_sel       (fwd_a_raw)
   );

   fwd_unit u_fwd_b (
      .ex_rs         (ex_rs2),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd_sel       (fwd_b_raw)
   );

   // State, wait counter, sticky error and performance counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Memory wait-state tracking; ERROR is left only through reset.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      unique case (state_q)
         RUN: begin
            if (!ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = ERROR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ERROR: begin
            mem_err_d = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Priority: freeze > branch flush > load-use bubble > advance.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_stall  = 1'b0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!rst_n || freeze) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_stall  = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   assign fwd_a_sel = rst_n ? fwd_a_raw : FWD_RF;
   assign fwd_b_sel = rst_n ? fwd_b_raw : FWD_RF;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule : hazard_ctrl
